expmul_pipe: RTL and testbench
==============================

EXPMUL_PIPE -- requirements
Module: expmul_pipe

Interface
REQ-001 Parameter DATA_W, default 16: signed fixed-point element and score width.
REQ-002 Parameter FRAC_W, default 8: fractional bits of all fixed-point quantities; SHALL satisfy FRAC_W < DATA_W.
REQ-003 Parameter VEC_LEN, default 8: elements per vector.
REQ-004 Parameter LANES, default 2: elements multiplied per cycle; SHALL divide VEC_LEN evenly; BEATS = VEC_LEN/LANES.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 vld_in  input  1  upstream offers a, b, vec_in.
REQ-008 rdy_out  output  1  block can accept input.
REQ-009 vld_out  output  1  vec_out holds a valid result.
REQ-010 rdy_in  input  1  downstream accepts vec_out.
REQ-011 a  input  DATA_W  signed score.
REQ-012 b  input  DATA_W  signed running maximum.
REQ-013 vec_in  input  VEC_LEN*DATA_W  signed elements; element i at bits [i*DATA_W +: DATA_W].
REQ-014 vec_out  output  VEC_LEN*DATA_W  signed result, same packing.
REQ-015 pos_err  output  1  sticky flag: some accepted transaction had a > b.

Function
REQ-016 Result SHALL be vec_out[i] = approx exp(a-b) * vec_in[i], computed bit-exactly per REQ-017..REQ-022.
REQ-017 d = a - b at DATA_W+1 bits signed; if d > 0, d SHALL be clamped to 0 and pos_err SHALL be set.
REQ-018 t = d + (d>>>1) - (d>>>4), arithmetic shifts, at DATA_W+2 bits signed (log2e approximation 1.4375).
REQ-019 u = -t (nonnegative); k = u >> FRAC_W; f = u mod 2^FRAC_W.
REQ-020 Scale s = 2^FRAC_W - (f >> 1), unsigned, FRAC_W+1 bits.
REQ-021 vec_out[i] = (vec_in[i] * s) >>> (FRAC_W + k), arithmetic shift (floor); product held at DATA_W+FRAC_W+2 bits with no overflow.
REQ-022 If FRAC_W + k >= DATA_W + FRAC_W + 1, vec_out[i] SHALL be 0 for nonnegative and -1 for negative vec_in[i] (full arithmetic shift-out).
REQ-023 FSM states IDLE, SCALE, COMPUTE, DONE.
REQ-024 IDLE: rdy_out = 1; on vld_in && rdy_out, register a, b, vec_in and go to SCALE; otherwise stay in IDLE.
REQ-025 SCALE: compute and register s, k, clamp flag; go to COMPUTE with beat counter = 0; rdy_out = 0.
REQ-026 COMPUTE: each cycle write elements [beat*LANES +: LANES] of the output register; increment beat; after beat BEATS-1 go to DONE.
REQ-027 DONE: vld_out = 1; vec_out and vld_out SHALL be stable while rdy_in = 0; on rdy_in go to IDLE.
REQ-028 rdy_out SHALL be 1 only in IDLE; vld_out SHALL be 1 only in DONE.
REQ-029 Latency: vld_out SHALL rise BEATS+1 rising edges after the accepting edge; throughput is one vector per BEATS+3 cycles minimum.
REQ-030 Inputs SHALL be sampled only at the accepting edge; changes to a, b or vec_in afterwards SHALL not affect the result.
REQ-031 vld_in while not in IDLE SHALL be ignored and SHALL not be dropped silently: upstream holds it per handshake.

Reset
REQ-032 While rst = 0: state = IDLE, beat counter = 0, vec_out = 0, vld_out = 0, pos_err = 0, captured registers = 0; rdy_out = 1 after release.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately, without producing a partial vld_out.
REQ-034 pos_err SHALL clear only on reset.

Verification (DATA_W=16, FRAC_W=8, VEC_LEN=8, LANES=2)
REQ-035 a=b=0x0100, vec_in all 0x0100 -> s=256, k=0, vec_out all 0x0100, vld_out rises 5 edges after accept.
REQ-036 a=0, b=0x0100 (d=-1.0), vec_in[0]=0x0100, vec_in[1]=0xFF00 -> s=200, k=1; vec_out[0]=100, vec_out[1]=-100; pos_err=0.
REQ-037 a=0x0200, b=0x0100 -> d clamped to 0, vec_out = vec_in, pos_err=1 and remains 1 over later transactions.
REQ-038 a=0x8000, b=0x7FFF -> k >= 24; vec_out[i]=0 for positive elements, -1 (0xFFFF) for negative elements.
REQ-039 Hold rdy_in=0 for 10 cycles in DONE while toggling vld_in and inputs -> vec_out and vld_out stable, rdy_out=0; release rdy_in -> IDLE next edge.
REQ-040 Assert rst during COMPUTE beat 2 -> vld_out=0, vec_out=0, rdy_out=1 after release; next transaction produces a correct result.

Source files
------------

// File: rtl/expmul_pipe_if.sv
// rtl/expmul_pipe_if.sv - handshake and data bundle between expmul_pipe and its neighbours
interface expmul_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 8
);
  logic                      vld_in;
  logic                      rdy_out;
  logic                      vld_out;
  logic                      rdy_in;
  logic [DATA_W-1:0]         a;
  logic [DATA_W-1:0]         b;
  logic [VEC_LEN*DATA_W-1:0] vec_in;
  logic [VEC_LEN*DATA_W-1:0] vec_out;
  logic                      pos_err;

  modport master (
    output vld_in, rdy_in, a, b, vec_in,
    input  rdy_out, vld_out, vec_out, pos_err
  );

  modport slave (
    input  vld_in, rdy_in, a, b, vec_in,
    output rdy_out, vld_out, vec_out, pos_err
  );
endinterface

// File: rtl/expmul_pipe.sv
// rtl/expmul_pipe.sv - scales a vector by approx exp(a-b), LANES elements per cycle
module expmul_pipe #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int VEC_LEN = 8,
  parameter int LANES   = 2
) (
  input  logic         clk,
  input  logic         rst,
  expmul_pipe_if.slave bus
);
  localparam int BEATS = VEC_LEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW1   = DATA_W + 1;
  localparam int TW    = DATA_W + 2;
  localparam int PW    = DATA_W + FRAC_W + 2;
  localparam int KW    = TW - FRAC_W;
  localparam int SW    = KW + 1;
  localparam int VW    = VEC_LEN * DATA_W;

  typedef enum logic [1:0] {IDLE, SCALE, COMPUTE, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [VW-1:0]     vec_q, out_q;
  logic [BW-1:0]     beat;
  logic [FRAC_W:0]   s_q;
  logic [KW-1:0]     k_q;
  logic              clamp_q, pos_err_q;
  logic              rdy, vld, last_beat;

  assign last_beat   = (beat == BW'(BEATS - 1));
  assign bus.rdy_out = rdy;
  assign bus.vld_out = vld;
  assign bus.vec_out = out_q;
  assign bus.pos_err = pos_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    vld       = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.vld_in) state_nxt = SCALE;
      end
      SCALE:   state_nxt = COMPUTE;
      COMPUTE: if (last_beat) state_nxt = DONE;
      DONE: begin
        vld = 1'b1;
        if (bus.rdy_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // exp(d) ~= 2^(d*log2e); the fractional power of two is linearised as 1 - f/2
  logic signed [DW1-1:0] d_raw, d_cl;
  logic signed [TW-1:0]  d_ext, t;
  logic [TW-1:0]         u;
  logic [FRAC_W-1:0]     f;
  logic [FRAC_W:0]       s_c;
  logic                  clamp_c;

  always_comb begin
    d_raw   = $signed({a_q[DATA_W-1], a_q}) - $signed({b_q[DATA_W-1], b_q});
    clamp_c = !d_raw[DW1-1] && (d_raw != '0);
    d_cl    = clamp_c ? '0 : d_raw;
    d_ext   = {d_cl[DW1-1], d_cl};
    t       = d_ext + (d_ext >>> 1) - (d_ext >>> 4);
    u       = -t;
    f       = u[FRAC_W-1:0];
    s_c     = {1'b1, {FRAC_W{1'b0}}} - {1'b0, f >> 1};
  end

  logic [SW-1:0] shamt;
  logic          sat;

  assign shamt = {1'b0, k_q} + SW'(FRAC_W);
  assign sat   = (shamt >= SW'(PW - 1));

  function automatic logic [DATA_W-1:0] scale_elem(
    input logic [DATA_W-1:0] e,
    input logic [FRAC_W:0]   s,
    input logic [SW-1:0]     sh,
    input logic              full_out
  );
    logic signed [PW-1:0] e_ext, s_ext, prod;
    e_ext = {{(PW-DATA_W){e[DATA_W-1]}}, e};
    s_ext = {{(PW-FRAC_W-1){1'b0}}, s};
    prod  = e_ext * s_ext;
    if (full_out) return {DATA_W{e[DATA_W-1]}};
    return DATA_W'(prod >>> sh);
  endfunction

  logic [DATA_W-1:0] lane_res [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_res[l] = scale_elem(vec_q[(int'(beat) * LANES + l) * DATA_W +: DATA_W],
                               s_q, shamt, sat);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      vec_q     <= '0;
      out_q     <= '0;
      beat      <= '0;
      s_q       <= '0;
      k_q       <= '0;
      clamp_q   <= 1'b0;
      pos_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.vld_in) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            vec_q <= bus.vec_in;
          end
        end
        SCALE: begin
          s_q     <= s_c;
          k_q     <= u[TW-1:FRAC_W];
          clamp_q <= clamp_c;
          beat    <= '0;
        end
        COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            out_q[(int'(beat) * LANES + l) * DATA_W +: DATA_W] <= lane_res[l];
          end
          pos_err_q <= pos_err_q | clamp_q;
          beat      <= last_beat ? '0 : beat + BW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_expmul_pipe.sv
// tb/tb_expmul_pipe.sv - directed vectors with a queue scoreboard for expmul_pipe
module tb_expmul_pipe;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int VEC_LEN = 8;
  localparam int LANES   = 2;
  localparam int VW      = VEC_LEN * DATA_W;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    logic pos;
    int   id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  expmul_pipe_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN)) bus ();

  expmul_pipe #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .VEC_LEN(VEC_LEN),
    .LANES  (LANES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   next_id  = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input vec_t act, input vec_t req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic vec_t pk(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  always @(negedge clk) begin
    if (bus.vld_out && bus.rdy_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got vec_out %h, want no output", bus.vec_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("vec_out#%0d", e.id), bus.vec_out, e.vec);
        check($sformatf("pos_err#%0d", e.id), vec_t'(bus.pos_err), vec_t'(e.pos));
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input vec_t vin,
                      input vec_t vexp, input logic pexp, input bit stall);
    bit acc;
    int n;
    bus.a      = a;
    bus.b      = b;
    bus.vec_in = vin;
    bus.vld_in = 1'b1;
    bus.rdy_in = !stall;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      acc = bus.rdy_out;
      @(posedge clk);
      #1;
      n++;
    end
    bus.vld_in = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got rdy_out 0 for %0d cycles, want 1", n);
      return;
    end
    exp_q.push_back('{vexp, pexp, next_id});
    next_id++;
    bus.a      = 16'($urandom);
    bus.b      = 16'($urandom);
    bus.vec_in = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!bus.vld_out && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", vec_t'(n), vec_t'(5));
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        check("stall_vld_out", vec_t'(bus.vld_out), vec_t'(1));
        check("stall_rdy_out", vec_t'(bus.rdy_out), vec_t'(0));
        check("stall_vec_out", bus.vec_out, vexp);
        bus.vld_in = i[0];
        bus.a      = 16'($urandom);
        bus.vec_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
      end
      bus.vld_in = 1'b0;
      bus.rdy_in = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_rdy_out", vec_t'(bus.rdy_out), vec_t'(1));
    check("idle_vld_out", vec_t'(bus.vld_out), vec_t'(0));
  endtask

  vec_t v_ones, v2_in, v2_out, v3, v4_in, v4_out, v5_in, v5_out, v6_in, v6_out;

  initial begin
    v_ones = {8{16'h0100}};
    v2_in  = pk(16'h0100, 16'hFF00, 16'h0200, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000);
    v2_out = pk(16'h0064, 16'hFF9C, 16'h00C8, 16'h31FF, 16'hCE00, 16'h0000, 16'hFFFF, 16'h0000);
    v3     = pk(16'h1234, 16'hFEDC, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 16'h00FF);
    v4_in  = pk(16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0005);
    v4_out = pk(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
    v5_in  = pk(16'h0100, 16'hFF00, 16'h0003, 16'hFFFD, 16'h7FFF, 16'h8000, 16'h0000, 16'h0010);
    v5_out = pk(16'h00A4, 16'hFF5C, 16'h0001, 16'hFFFE, 16'h51FF, 16'hAE00, 16'h0000, 16'h000A);
    v6_in  = pk(16'h0100, 16'hFF00, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    v6_out = pk(16'h0024, 16'hFFDC, 16'h0090, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    bus.vld_in = 1'b0;
    bus.rdy_in = 1'b1;
    bus.a      = '0;
    bus.b      = '0;
    bus.vec_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld_out", vec_t'(bus.vld_out), vec_t'(0));
    check("reset_vec_out", bus.vec_out, vec_t'(0));
    check("reset_pos_err", vec_t'(bus.pos_err), vec_t'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_rdy_out", vec_t'(bus.rdy_out), vec_t'(1));

    send(16'h0100, 16'h0100, v_ones, v_ones, 1'b0, 1'b0);
    send(16'h0000, 16'h0100, v2_in, v2_out, 1'b0, 1'b0);
    send(16'h0200, 16'h0100, v3, v3, 1'b1, 1'b0);
    send(16'h8000, 16'h7FFF, v4_in, v4_out, 1'b1, 1'b0);
    send(16'h0000, 16'h0200, v6_in, v6_out, 1'b1, 1'b1);

    bus.a      = 16'h0000;
    bus.b      = 16'h0100;
    bus.vec_in = v2_in;
    bus.vld_in = 1'b1;
    @(posedge clk);
    #1;
    bus.vld_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("abort_vld_out", vec_t'(bus.vld_out), vec_t'(0));
    check("abort_vec_out", bus.vec_out, vec_t'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rdy_out", vec_t'(bus.rdy_out), vec_t'(1));
    check("abort_pos_err", vec_t'(bus.pos_err), vec_t'(0));
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_output", vec_t'(bus.vld_out), vec_t'(0));

    send(16'h0000, 16'h0080, v5_in, v5_out, 1'b0, 1'b0);
    send(16'h0100, 16'h0100, v_ones, v_ones, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", vec_t'(exp_q.size()), vec_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
